// File: rtl/issue_queue_if.sv
// ----------------------------------------------------------------------------
// issue_queue_if
// Purpose : bundles the decode->queue and queue->issue handshake signals of
//           the issue queue, plus the occupancy report.
//
// Handshake (both channels): a transfer happens on a rising edge where the
// producer's valid and the consumer's allow/ready are both high. The producer
// holds valid and its payload until the transfer happens. Allow/ready may be
// low or high at any time.
//   decode channel : ds_to_is_valid / ds_to_is_bus  with IQ_allowin
//   issue channel  : iq_to_is_valid / iq_to_is_bus  with is_allowin
//
// Modports
//   slave  : the queue side (takes decode entries, drives the head entry)
//   master : the pipeline side (offers decode entries, consumes the head)
// ----------------------------------------------------------------------------
interface issue_queue_if #(
  parameter int DEPTH   = 4,
  parameter int DATA_WD = 211
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               ds_to_is_valid;
  logic [DATA_WD-1:0] ds_to_is_bus;
  logic               IQ_allowin;
  logic               is_allowin;
  logic               iq_to_is_valid;
  logic [DATA_WD-1:0] iq_to_is_bus;
  logic [CNT_W-1:0]   iq_count;

  modport slave (
    input  ds_to_is_valid,
    input  ds_to_is_bus,
    output IQ_allowin,
    input  is_allowin,
    output iq_to_is_valid,
    output iq_to_is_bus,
    output iq_count
  );

  modport master (
    output ds_to_is_valid,
    output ds_to_is_bus,
    input  IQ_allowin,
    output is_allowin,
    input  iq_to_is_valid,
    input  iq_to_is_bus,
    input  iq_count
  );
endinterface

// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue
// Purpose : circular-buffer FIFO of decoded instructions between the decode
//           and issue stages. No empty bypass: an entry accepted at edge N is
//           visible at the head only after edge N.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; clears pointers and occupancy
//   iq_flush : synchronous flush; blocks both channels this cycle and empties
//              the queue at the next edge
//   q        : issue_queue_if.slave (decode channel in, issue channel out,
//              iq_count occupancy)
// ----------------------------------------------------------------------------
module issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_WD = 211
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iq_flush,
  issue_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WD-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_allowin;
  logic w_valid;
  logic w_enq;
  logic w_deq;

  // Allowin looks only at the registered count, never at is_allowin, so a
  // full queue cannot take a new entry in the same cycle one leaves.
  assign w_allowin = (r_count != FULL_CNT) && !iq_flush;
  assign w_valid   = (r_count != '0) && !iq_flush;
  // Both handshakes already include !iq_flush, which gives flush priority.
  assign w_enq     = q.ds_to_is_valid && w_allowin;
  assign w_deq     = w_valid && q.is_allowin;

  assign q.IQ_allowin     = w_allowin;
  assign q.iq_to_is_valid = w_valid;
  assign q.iq_to_is_bus   = r_mem[r_head];
  assign q.iq_count       = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || iq_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is not reset; stale contents are unreachable once the
  // pointers are cleared. w_enq is already suppressed by flush; reset is
  // added so a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) r_mem[r_tail] <= q.ds_to_is_bus;
  end
endmodule
